// File: rtl/tmp_pkg.sv
// tmp_pkg: shared declarations for the temperature-sense conversion counter.
//   state_e          - conversion FSM states (ARMED, COUNT, HOLD)
//   *_DEF localparams - default parameter values used by the top and interface
package tmp_pkg;

  typedef enum logic [1:0] {
    ARMED = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int CNT_W_DEF       = 12;
  localparam int AVG_LOG2_DEF    = 2;
  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/tmp_conv_counter_if.sv
// tmp_conv_counter_if: result hand-off bundle between the conversion counter
// and its consumer.
//   result       - averaged ramp count (CNT_W bits)
//   result_valid - result available, held until accepted
//   result_ready - consumer accepts result
//   overflow     - at least one sample in the current result saturated
// Modports: master (counter side), slave (consumer side).
interface tmp_conv_counter_if
  import tmp_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) ();

  logic [CNT_W-1:0] result;
  logic             result_valid;
  logic             result_ready;
  logic             overflow;

  modport master (
    output result,
    output result_valid,
    output overflow,
    input  result_ready
  );

  modport slave (
    input  result,
    input  result_valid,
    input  overflow,
    output result_ready
  );

endinterface

// File: rtl/tmp_sync.sv
// tmp_sync: multi-flop synchronizer for a single asynchronous bit.
//   clk   - destination clock
//   reset - asynchronous, active-high; clears every stage to 0
//   d     - asynchronous input
//   q     - synchronized output, SYNC_STAGES cycles of latency
module tmp_sync
  import tmp_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= sync_d;
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/tmp_conv_counter.sv
// tmp_conv_counter: counts ramp-phase cycles until the comparator trips,
// averages 2^AVG_LOG2 such samples and presents the mean with a
// valid/ready hand-off.
//   clk     - rising-edge clock shared with the temperature-sense controller
//   reset   - asynchronous, active-high
//   meas_en - ramp-phase window, already synchronous to clk
//   cmp     - raw asynchronous comparator output
//   res_if  - result / result_valid / result_ready / overflow bundle
//   abort   - one-cycle pulse when the window closes before the comparator trips
//   busy    - high while counting a sample
module tmp_conv_counter
  import tmp_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int AVG_LOG2    = AVG_LOG2_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  meas_en,
  input  logic                  cmp,
  tmp_conv_counter_if.master    res_if,
  output logic                  abort,
  output logic                  busy
);

  // acc holds up to 2^AVG_LOG2 samples of at most 2^CNT_W-1, so it never wraps.
  localparam int ACC_W = CNT_W + AVG_LOG2;
  localparam int IDX_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'((1 << AVG_LOG2) - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic cmp_s;

  tmp_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (cmp),
    .q    (cmp_s)
  );

  state_e           state_q, state_d;
  logic             meas_en_d1_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] result_q, result_d;
  logic             result_valid_q, result_valid_d;
  logic             overflow_q, overflow_d;
  logic             abort_q, abort_d;

  logic             meas_rise;
  logic [ACC_W-1:0] acc_sum;

  assign meas_rise = meas_en & ~meas_en_d1_q;
  // Sum including the sample being captured this cycle.
  assign acc_sum   = acc_q + ACC_W'(cnt_q);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    acc_d          = acc_q;
    idx_d          = idx_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    overflow_d     = overflow_q;
    abort_d        = 1'b0;

    case (state_q)
      ARMED: begin
        if (meas_rise) begin
          cnt_d   = '0;
          state_d = COUNT;
        end
      end

      COUNT: begin
        // A comparator trip wins over the window closing in the same cycle.
        if (cmp_s) begin
          acc_d = acc_sum;
          if (cnt_q == CNT_MAX) overflow_d = 1'b1;
          if (idx_q == IDX_LAST) begin
            idx_d          = '0;
            result_d       = acc_sum[ACC_W-1:AVG_LOG2];
            result_valid_d = 1'b1;
            state_d        = HOLD;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ARMED;
          end
        end else if (meas_en) begin
          cnt_d = sat_inc(cnt_q);
        end else begin
          abort_d = 1'b1;
          state_d = ARMED;
        end
      end

      HOLD: begin
        // Window rises here are deliberately dropped until the result is taken.
        if (result_valid_q && res_if.result_ready) begin
          result_valid_d = 1'b0;
          acc_d          = '0;
          idx_d          = '0;
          overflow_d     = 1'b0;
          state_d        = ARMED;
        end
      end

      default: state_d = ARMED;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ARMED;
      meas_en_d1_q   <= 1'b0;
      cnt_q          <= '0;
      acc_q          <= '0;
      idx_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
      abort_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      meas_en_d1_q   <= meas_en;
      cnt_q          <= cnt_d;
      acc_q          <= acc_d;
      idx_q          <= idx_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      overflow_q     <= overflow_d;
      abort_q        <= abort_d;
    end
  end

  assign res_if.result       = result_q;
  assign res_if.result_valid = result_valid_q;
  assign res_if.overflow     = overflow_q;
  assign abort               = abort_q;
  assign busy                = (state_q == COUNT);

endmodule

// File: tb/tb_tmp_conv_counter.sv
// tb_tmp_conv_counter: randomized self-checking bench for tmp_conv_counter.
// The reference model keeps a queue of captured sample values; a result is
// the truncated mean of NAVG samples, overflow is set when any sample hit
// the saturation value, and conversions started while a result waits are lost.
module tb_tmp_conv_counter;

  localparam int CNT_W       = 8;
  localparam int AVG_LOG2    = 2;
  localparam int SYNC_STAGES = 2;
  localparam int NAVG        = 1 << AVG_LOG2;
  localparam int SMAX        = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  logic meas_en;
  logic cmp;
  logic abort;
  logic busy;

  always #5 clk = ~clk;

  tmp_conv_counter_if #(.CNT_W(CNT_W)) res_if ();

  tmp_conv_counter #(
    .CNT_W      (CNT_W),
    .AVG_LOG2   (AVG_LOG2),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .meas_en(meas_en),
    .cmp    (cmp),
    .res_if (res_if),
    .abort  (abort),
    .busy   (busy)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int samp_q[$];
  bit model_hold = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int model_result();
    int sum = 0;
    foreach (samp_q[i]) sum += samp_q[i];
    return sum / NAVG;
  endfunction

  function automatic bit model_ovf();
    foreach (samp_q[i]) if (samp_q[i] == SMAX) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_capture(input int s);
    if (model_hold) return;
    samp_q.push_back((s > SMAX) ? SMAX : s);
    if (samp_q.size() == NAVG) model_hold = 1'b1;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "_valid"}, res_if.result_valid, model_hold);
    check({tag, "_ovf"}, res_if.overflow, model_ovf());
    if (model_hold) check({tag, "_result"}, res_if.result, model_result());
  endtask

  // One conversion whose comparator trips after s COUNT cycles. With prio set
  // (s >= 2) the window closes in the same cycle the comparator is seen.
  task automatic conv(input int s, input bit prio);
    if (s == 0) begin
      cmp = 1'b1;
      repeat (3) @(negedge clk);
      meas_en = 1'b1;
      @(negedge clk);
      check("busy_start", busy, !model_hold);
      repeat (3) @(negedge clk);
    end else begin
      meas_en = 1'b1;
      if (s == 1) cmp = 1'b1;
      @(negedge clk);
      check("busy_start", busy, !model_hold);
      if (s > 1) begin
        repeat (s - 2) @(negedge clk);
        cmp = 1'b1;
      end
      if (prio && s >= 2) begin
        repeat (2) @(negedge clk);
        meas_en = 1'b0;
        repeat (2) begin
          @(negedge clk);
          check("prio_no_abort", abort, 0);
        end
      end else begin
        repeat (3) @(negedge clk);
      end
    end
    meas_en = 1'b0;
    cmp     = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_idle", busy, 0);
    model_capture(s);
    check_outputs("conv");
  endtask

  // Window closes after d COUNT cycles with the comparator still low.
  task automatic abort_conv(input int d);
    meas_en = 1'b1;
    repeat (d) @(negedge clk);
    check("abort_busy", busy, !model_hold);
    meas_en = 1'b0;
    @(negedge clk);
    check("abort_pulse", abort, !model_hold);
    check("abort_busy_off", busy, 0);
    @(negedge clk);
    check("abort_width", abort, 0);
    repeat (2) @(negedge clk);
    check_outputs("abort");
  endtask

  // Hold off the consumer for w cycles, then accept.
  task automatic accept(input int w);
    int held = model_result();
    res_if.result_ready = 1'b0;
    repeat (w) begin
      @(negedge clk);
      check("bp_valid", res_if.result_valid, 1);
      check("bp_result", res_if.result, held);
    end
    res_if.result_ready = 1'b1;
    @(negedge clk);
    res_if.result_ready = 1'b0;
    samp_q.delete();
    model_hold = 1'b0;
    check("acc_valid", res_if.result_valid, 0);
    check("acc_ovf", res_if.overflow, 0);
    @(negedge clk);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_result"}, res_if.result, 0);
    check({tag, "_valid"}, res_if.result_valid, 0);
    check({tag, "_ovf"}, res_if.overflow, 0);
    check({tag, "_abort"}, abort, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    int d;
    reset               = 1'b1;
    meas_en             = 1'b0;
    cmp                 = 1'b0;
    res_if.result_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset_checks("por");
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Averaging with backpressure and conversions lost while holding
    conv(100, 0);
    conv(101, 0);
    conv(102, 0);
    conv(104, 0);
    check("avg_result", res_if.result, 101);
    repeat (3) conv(20, 0);
    accept(20);

    // Abort, and comparator priority over window close
    conv(10, 0);
    abort_conv(10);
    conv(20, 0);
    conv(30, 1);
    conv(40, 0);
    check("abort_avg", res_if.result, 25);
    accept(0);

    // Saturation
    conv(300, 0);
    check("sat_ovf_early", res_if.overflow, 1);
    conv(0, 0);
    conv(1, 0);
    conv(2, 0);
    check("sat_result", res_if.result, 64);
    accept(2);

    // Asynchronous reset mid-count after two samples
    conv(5, 0);
    conv(6, 0);
    meas_en = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    reset_checks("midrst");
    meas_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    samp_q.delete();
    model_hold = 1'b0;
    repeat (3) @(negedge clk);
    repeat (4) conv(50, 0);
    check("rst_result", res_if.result, 50);
    accept(1);

    // Randomized conversions, aborts, stray ready and backpressure
    for (int r = 0; r < 10; r++) begin
      while (!model_hold) begin
        if (samp_q.size() < NAVG - 1) res_if.result_ready = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 4) == 0) begin
          d = $urandom_range(1, 40);
          abort_conv(d);
        end else begin
          case ($urandom_range(0, 7))
            0:       s = 0;
            1:       s = $urandom_range(250, 300);
            default: s = $urandom_range(1, 80);
          endcase
          conv(s, (s >= 2) ? 1'($urandom_range(0, 1)) : 1'b0);
        end
        res_if.result_ready = 1'b0;
      end
      if ($urandom_range(0, 1) == 1) conv($urandom_range(1, 30), 0);
      accept($urandom_range(0, 5));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tmp_conv_counter.md
TMP_CONV_COUNTER -- requirements
Module: tmp_conv_counter

Interface
REQ-001 SHALL have parameter CNT_W, default 12, ramp counter and result width in bits.
REQ-002 SHALL have parameter AVG_LOG2, default 2, log2 of conversions averaged per result (4 by default).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, comparator synchronizer depth (minimum 2).
REQ-004 SHALL have port clk, input, 1 bit, rising-edge clock shared with the temperature-sense controller.
REQ-005 SHALL have port reset, input, 1 bit, asynchronous, active-high.
REQ-006 SHALL have port meas_en, input, 1 bit, ramp-phase window: the controller's s_Cap2CMP, synchronous to clk.
REQ-007 SHALL have port cmp, input, 1 bit, raw asynchronous comparator output.
REQ-008 SHALL have port result, output, CNT_W bits, averaged ramp count.
REQ-009 SHALL have port result_valid, output, 1 bit, result available.
REQ-010 SHALL have port result_ready, input, 1 bit, consumer accepts result.
REQ-011 SHALL have port overflow, output, 1 bit, at least one sample in the current result saturated.
REQ-012 SHALL have port abort, output, 1 bit, one-cycle pulse when meas_en falls before the comparator trips.
REQ-013 SHALL have port busy, output, 1 bit, high in state COUNT.

Function
REQ-014 SHALL pass cmp through SYNC_STAGES flops to form cmp_s; meas_en SHALL NOT be synchronized.
REQ-015 SHALL detect a meas_en rise as meas_en=1 with its one-cycle-delayed copy at 0.
REQ-016 SHALL implement states ARMED, COUNT and HOLD.
REQ-017 SHALL, in ARMED, on a meas_en rise, clear cnt to 0 and enter COUNT.
REQ-018 SHALL, in COUNT with cmp_s=1, add cnt to acc, increment the sample index, and leave state:
  - to HOLD if the index wraps to 0 after 2^AVG_LOG2 samples;
  - to ARMED otherwise.
REQ-019 SHALL make sample value = number of prior COUNT cycles; cmp_s=1 on the first COUNT cycle yields 0.
REQ-020 SHALL, in COUNT with cmp_s=0 and meas_en=1, increment cnt, saturating at 2^CNT_W-1.
REQ-021 SHALL, when a sample is captured at saturation, accumulate 2^CNT_W-1 and set overflow, which stays set until the result is accepted.
REQ-022 SHALL, in COUNT with meas_en=0 and cmp_s=0, discard the sample, pulse abort for one cycle and return to ARMED, leaving acc and the index unchanged.
REQ-023 SHALL give cmp_s=1 priority when meas_en=0 occurs in the same cycle.
REQ-024 SHALL size acc at CNT_W+AVG_LOG2 bits, wrap-free by construction.
REQ-025 SHALL, on entry to HOLD, register result = acc >> AVG_LOG2 (truncated) and raise result_valid on the same edge.
REQ-026 SHALL hold result and result_valid stable in HOLD until result_valid & result_ready.
REQ-027 SHALL, on result_valid & result_ready, clear result_valid, acc, the index and overflow, and enter ARMED; the next meas_en rise is accepted one cycle later at the earliest.
REQ-028 SHALL ignore meas_en rises in HOLD; those conversions are lost.
REQ-029 SHALL ignore result_ready outside HOLD.

Reset
REQ-030 SHALL, on asynchronous reset assertion, force:
  - state=ARMED;
  - cnt, acc, index, result and the synchronizer flops to 0;
  - result_valid, overflow, abort and busy to 0.
REQ-031 SHALL discard any partial sample or average on a mid-operation reset.
REQ-032 SHALL count from the first meas_en rise after reset release.

Structure
REQ-033 SHALL place the state enum (ARMED, COUNT, HOLD) and parameter defaults in shared package tmp_pkg.
REQ-034 SHALL implement the synchronizer as sub-module tmp_sync, parameterized by SYNC_STAGES, with asynchronous reset to 0.
REQ-035 SHALL keep all other logic in tmp_conv_counter, with a single clk domain.

Verification
REQ-036 Single-sample timing (AVG_LOG2=0): meas_en rise; cmp raised so cmp_s=1 on the 37th COUNT cycle -> result=36, result_valid=1, overflow=0.
REQ-037 Averaging (AVG_LOG2=2): samples 100, 101, 102, 104 -> result=101 (407>>2), presented only after the 4th sample.
REQ-038 Saturation (CNT_W=4): cmp held 0 for 30 COUNT cycles, then cmp_s=1 -> sample 15, overflow=1 until acceptance.
REQ-039 Abort: meas_en drops after 10 COUNT cycles with cmp=0 -> abort high exactly 1 cycle, state ARMED, acc unchanged; meas_en=0 and cmp_s=1 in the same cycle -> sample captured, no abort.
REQ-040 Backpressure: result_ready=0 for 20 cycles with 3 meas_en pulses in HOLD -> result stable, pulses ignored; ready=1 -> valid drops next edge.
REQ-041 Reset mid-COUNT after 2 of 4 samples -> all outputs 0; 4 fresh samples of 50 -> result=50.
